// File: rtl/instr_sequencer.sv
// Issue side of the processor control FSM: hands {func,rx,ry} to the FSM, owns current_state,
// detects retirement, flags illegal/hung instructions. Define SEQ_PREFETCH_EN for a one-entry prefetch buffer.
module instr_sequencer #(
  parameter int MAX_STEPS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [9:0]       instr_data,
  output logic [3:0]       func,
  output logic [2:0]       input1,
  output logic [2:0]       input2,
  output logic [4:0]       current_state,
  input  logic [4:0]       next_state,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
  // instr_ready depends only on registered state, so it is stable for the whole cycle.
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [4:0] STEP_LIMIT = 5'(MAX_STEPS);

  state_t     state;
  logic [4:0] steps;
  logic       xfer;
  logic       finish;
  logic [9:0] issue_data;

  assign xfer   = instr_valid && instr_ready;
  assign finish = (state == EXEC) && ((next_state == 5'd0) || (steps == STEP_LIMIT));

`ifdef SEQ_PREFETCH_EN
  logic       pf_full;
  logic [9:0] pf_data;

  assign instr_ready = (state == IDLE) || !pf_full;
  // pf is only ever full while in EXEC, so this mux is correct from IDLE too
  assign issue_data  = pf_full ? pf_data : instr_data;
`else
  assign instr_ready = (state == IDLE);
  assign issue_data  = instr_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      func          <= 4'd0;
      input1        <= 3'd0;
      input2        <= 3'd0;
      current_state <= 5'd0;
      steps         <= 5'd0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      timeout       <= 1'b0;
      retired_count <= '0;
`ifdef SEQ_PREFETCH_EN
      pf_full       <= 1'b0;
      pf_data       <= 10'd0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            state                  <= EXEC;
            busy                   <= 1'b1;
            {func, input1, input2} <= issue_data;
            current_state          <= 5'd0;
            steps                  <= 5'd1;
          end
        end
        EXEC: begin
          if (finish) begin
            // Priority: illegal, then normal retire, then watchdog
            if (next_state == 5'd0 && current_state == 5'd0) begin
              illegal <= 1'b1;
            end else if (next_state == 5'd0) begin
              done          <= 1'b1;
              retired_count <= retired_count + CNT_W'(1);
            end else begin
              timeout <= 1'b1;
            end
            current_state <= 5'd0;
`ifdef SEQ_PREFETCH_EN
            if (pf_full || xfer) begin
              {func, input1, input2} <= issue_data;
              steps                  <= 5'd1;
              pf_full                <= 1'b0;
            end else begin
              state                  <= IDLE;
              busy                   <= 1'b0;
              {func, input1, input2} <= 10'd0;
              steps                  <= 5'd0;
            end
`else
            state                  <= IDLE;
            busy                   <= 1'b0;
            {func, input1, input2} <= 10'd0;
            steps                  <= 5'd0;
`endif
          end else begin
            current_state <= next_state;
            steps         <= steps + 5'd1;
`ifdef SEQ_PREFETCH_EN
            if (xfer) begin
              pf_data <= instr_data;
              pf_full <= 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural control-FSM model, vector table and scoreboard queue of
// expected {pulse kind, EXEC cycles, retired_count}.
module tb_instr_sequencer;
  localparam int CNT_W = 8;
  localparam int W     = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [9:0]       instr_data = 10'd0;
  logic [3:0]       func;
  logic [2:0]       input1;
  logic [2:0]       input2;
  logic [4:0]       current_state;
  logic [4:0]       next_state;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired_count;

  logic             stuck = 1'b0;
  logic [CNT_W-1:0] exp_retired = '0;
  logic [W-1:0]     exp_q[$];
  int               total = 0;
  int               passed = 0;
  int               b2b_cnt = 0;

  instr_sequencer #(.MAX_STEPS(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .func(func), .input1(input1), .input2(input2),
    .current_state(current_state), .next_state(next_state), .busy(busy), .done(done),
    .illegal(illegal), .timeout(timeout), .retired_count(retired_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Control FSM model: the state walks for each known opcode
  function automatic logic [4:0] fsm_next(input logic [3:0] f, input logic [4:0] s);
    logic [4:0] n;
    n = 5'd0;
    case (f)
      4'b0001: n = (s == 5'd0) ? 5'd1 : 5'd0;
      4'b0010: n = (s == 5'd0) ? 5'd2 : 5'd0;
      4'b0011: case (s) 5'd0: n = 5'd3; 5'd3: n = 5'd4; 5'd4: n = 5'd5; default: n = 5'd0; endcase
      4'b0100: case (s) 5'd0: n = 5'd7; 5'd7: n = 5'd8; 5'd8: n = 5'd9; default: n = 5'd0; endcase
      4'b0101: case (s) 5'd0: n = 5'd10; 5'd10: n = 5'd11; 5'd11: n = 5'd12; default: n = 5'd0; endcase
      default: n = 5'd0;
    endcase
    return n;
  endfunction

  always_comb next_state = stuck ? 5'd3 : fsm_next(func, current_state);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // driver tasks
  task automatic issue(input logic [9:0] d, input logic [1:0] kind, input logic [5:0] cyc);
    int waited;
    waited = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = d;
    while (!instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      fail("issue_wait");
      instr_valid = 1'b0;
      return;
    end
    if (kind == 2'd1) exp_retired = exp_retired + 1'b1;
    exp_q.push_back({kind, cyc, exp_retired});
    @(posedge clk);
  endtask

  task automatic release_bus();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic release_and_check(input logic [9:0] d);
    @(negedge clk);
    instr_valid = 1'b0;
    check("issue_latch", {func, input1, input2}, d);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 300);
    if (exp_q.size() != 0 || busy) fail("quiet_timeout");
  endtask

  // scoreboard monitor: counts EXEC cycles and matches each pulse to the expected queue
  int mon_cnt = 0;
  always @(negedge clk) begin
    logic [1:0]   kind;
    logic [W-1:0] e;
    if (reset) begin
      mon_cnt = 0;
    end else begin
      if (done || illegal || timeout) begin
        check("pulse_onehot", 32'(done) + 32'(illegal) + 32'(timeout), 32'd1);
        kind = done ? 2'd1 : (illegal ? 2'd2 : 2'd3);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse: got kind %0d expected no pulse", kind);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind", kind, e[15:14]);
          check("sb_exec_cycles", mon_cnt, e[13:8]);
          check("sb_retired_count", retired_count, e[7:0]);
        end
        if (busy) b2b_cnt++;
        else check("idle_outputs_zero", {func, input1, input2, current_state}, 32'd0);
        mon_cnt = busy ? 1 : 0;
      end else if (busy) begin
        mon_cnt++;
      end
`ifndef SEQ_PREFETCH_EN
      if (busy) check("ready_low_in_exec", instr_ready, 32'd0);
`endif
    end
  end

  typedef struct {
    logic [9:0] instr;
    logic [1:0] kind;
    logic [5:0] cycles;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [4:0] trace[4];
    int n;
    vecs[0] = '{10'b0001_011_100, 2'd1, 6'd2};
    vecs[1] = '{10'b0010_101_110, 2'd1, 6'd2};
    vecs[2] = '{10'b0011_111_000, 2'd1, 6'd4};
    vecs[3] = '{10'b0100_010_011, 2'd1, 6'd4};
    vecs[4] = '{10'b0101_110_001, 2'd1, 6'd4};
    vecs[5] = '{10'b1111_001_001, 2'd2, 6'd1};
    vecs[6] = '{10'b0000_000_000, 2'd2, 6'd1};
    vecs[7] = '{10'b0110_100_100, 2'd2, 6'd1};
    trace[0] = 5'd0; trace[1] = 5'd3; trace[2] = 5'd4; trace[3] = 5'd5;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {func, input1, input2, current_state}, 32'd0);
    check("rst_flags", {busy, done, illegal, timeout}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_ready", instr_ready, 32'd1);
    reset = 1'b0;

    // add walk 0,3,4,5 then 0 with a single-cycle done
    issue(10'b0011_001_010, 2'd1, 6'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) instr_valid = 1'b0;
      check("add_trace_state", current_state, trace[k]);
      check("add_trace_busy", busy, 32'd1);
    end
    @(negedge clk);
    check("add_done_pulse", {done, current_state}, {1'b1, 5'd0});
    @(negedge clk);
    check("add_done_one_cycle", done, 32'd0);
    check("add_retired", retired_count, 32'd1);

    // unknown func -> illegal after one EXEC cycle, count unchanged
    issue(10'b1111_000_000, 2'd2, 6'd1);
    release_and_check(10'b1111_000_000);
    wait_quiet();
    check("illegal_retired_same", retired_count, exp_retired);
    check("illegal_func_idle", func, 32'd0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].instr, vecs[i].kind, vecs[i].cycles);
      release_and_check(vecs[i].instr);
      wait_quiet();
    end

    // hung FSM -> watchdog after MAX_STEPS cycles
    stuck = 1'b1;
    issue(10'b0011_001_001, 2'd3, 6'd8);
    release_bus();
    wait_quiet();
    check("timeout_state_zero", current_state, 32'd0);
    check("timeout_retired_same", retired_count, exp_retired);
    stuck = 1'b0;

    // reset in the middle of sub at state 01000
    issue(10'b0100_001_001, 2'd1, 6'd4);
    release_bus();
    n = 0;
    while (current_state != 5'd8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (current_state != 5'd8) fail("sub_reach_state8");
    reset = 1'b1;
    exp_q.delete();
    exp_retired = '0;
    @(negedge clk);
    check("midrst_outputs", {func, input1, input2, current_state}, 32'd0);
    check("midrst_flags", {busy, done, illegal, timeout}, 32'd0);
    check("midrst_retired", retired_count, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_quiet", {busy, done, illegal, timeout}, 32'd0);

    // back-to-back: load then xor with valid held
    b2b_cnt = 0;
    issue(10'b0001_000_001, 2'd1, 6'd2);
    issue(10'b0101_010_011, 2'd1, 6'd4);
    release_bus();
    wait_quiet();
`ifdef SEQ_PREFETCH_EN
    check("b2b_no_bubble", b2b_cnt, 32'd1);
`else
    check("b2b_idle_bubble", b2b_cnt, 32'd0);
`endif
    check("b2b_retired", retired_count, exp_retired);

    // 256 loads: retired_count wraps through 255 -> 0
    for (int i = 0; i < 256; i++) begin
      issue(10'(($urandom_range(0, 63)) | 10'b0001_000_000) & 10'b0001_111_111, 2'd1, 6'd2);
      release_bus();
    end
    wait_quiet();
    check("wrap_retired", retired_count, exp_retired);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
